// File: rtl/bignum_multiplier_cfg_if.sv
`default_nettype none
// ============================================================================
// Module      : bignum_multiplier_cfg_if
// Description : Operand-in / product-out stream bundle for the bignum multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
interface bignum_multiplier_cfg_if #(
    parameter int REGISTER_SIZE = 32,
    parameter int MAX_BITS      = 4096
);
    localparam int MAX_BLOCKS = MAX_BITS / REGISTER_SIZE;
    localparam int KW         = $clog2(MAX_BLOCKS) + 1;

    logic [REGISTER_SIZE-1:0] n_in;
    logic [REGISTER_SIZE-1:0] m_in;
    logic                     valid_in;
    logic [KW-1:0]            num_blocks_in;
    logic                     low_half_in;
    logic                     ready_out;
    logic [REGISTER_SIZE-1:0] data_out;
    logic                     valid_out;
    logic                     ready_in;
    logic                     final_out;

    modport master (
        output n_in, m_in, valid_in, num_blocks_in, low_half_in, ready_in,
        input  ready_out, data_out, valid_out, final_out
    );

    modport slave (
        input  n_in, m_in, valid_in, num_blocks_in, low_half_in, ready_in,
        output ready_out, data_out, valid_out, final_out
    );
endinterface

`default_nettype wire

// File: rtl/bignum_multiplier_cfg.sv
`default_nettype none
// ============================================================================
// Module      : bignum_multiplier_cfg
// Description : Block-serial schoolbook multiplier, run-time length K, optional low half.
// Revision    : 1.0 - initial release
// ============================================================================
module bignum_multiplier_cfg #(
    parameter int REGISTER_SIZE = 32,
    parameter int MAX_BITS      = 4096
) (
    input  wire logic               clk_in,
    input  wire logic               rst_n_in,
    bignum_multiplier_cfg_if.slave  bus
);
    localparam int W          = REGISTER_SIZE;
    localparam int MAX_BLOCKS = MAX_BITS / W;
    localparam int AW         = $clog2(MAX_BLOCKS);
    localparam int KW         = AW + 1;
    localparam logic [KW-1:0] C_MAX_K = KW'(MAX_BLOCKS);
    localparam logic [KW-1:0] C_ONE   = KW'(1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LOAD    = 2'd1;
    localparam logic [1:0] S_COMPUTE = 2'd2;
    localparam logic [1:0] S_OUTPUT  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          armed_q;
    logic [KW-1:0] k_q, k_d;
    logic          low_q, low_d;
    logic [KW-1:0] cnt_q, cnt_d;
    logic [KW-1:0] i_q, i_d;
    logic [KW-1:0] j_q, j_d;
    logic [W-1:0]  carry_q, carry_d;
    logic [KW-1:0] out_idx_q, out_idx_d;

    logic [W-1:0] n_mem   [MAX_BLOCKS];
    logic [W-1:0] m_mem   [MAX_BLOCKS];
    logic [W-1:0] acc_mem [2*MAX_BLOCKS];

    logic          ready_w;
    logic          valid_w;
    logic          beat_in;
    logic          beat_out;
    logic [KW-1:0] k_eff;
    logic [KW-1:0] load_idx;
    logic [KW-1:0] load_k;
    logic          last_load;
    logic [KW-1:0] acc_idx;
    logic          row_done;
    logic          row_last;
    logic [KW-1:0] out_last_idx;
    logic          out_last;
    logic [W-1:0]  opn;
    logic [2*W-1:0] mac;

    always_comb begin
        k_eff = bus.num_blocks_in;
        if (bus.num_blocks_in == '0 || bus.num_blocks_in > C_MAX_K) begin
            k_eff = C_MAX_K;
        end
        load_idx  = (state_q == S_IDLE) ? '0 : cnt_q;
        load_k    = (state_q == S_IDLE) ? k_eff : k_q;
        last_load = (load_idx == load_k - C_ONE);
        beat_in   = bus.valid_in && ready_w;
        beat_out  = valid_w && bus.ready_in;

        acc_idx  = i_q + j_q;
        // Low-half rows stop at block K-1; the carry out of that block is dropped.
        row_done = low_q ? (acc_idx == k_q - C_ONE) : (i_q == k_q);
        row_last = (j_q == k_q - C_ONE);
        opn      = (i_q < k_q) ? n_mem[i_q[AW-1:0]] : '0;
        mac      = {{W{1'b0}}, opn} * {{W{1'b0}}, m_mem[j_q[AW-1:0]]}
                 + {{W{1'b0}}, acc_mem[acc_idx]} + {{W{1'b0}}, carry_q};

        // 2K wraps to 0 when K = MAX_BLOCKS; minus one still lands on 2K-1.
        out_last_idx = low_q ? (k_q - C_ONE) : ((k_q << 1) - C_ONE);
        out_last     = (out_idx_q == out_last_idx);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= S_IDLE;
            armed_q   <= 1'b0;
            k_q       <= C_MAX_K;
            low_q     <= 1'b0;
            cnt_q     <= '0;
            i_q       <= '0;
            j_q       <= '0;
            carry_q   <= '0;
            out_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            armed_q   <= 1'b1;
            k_q       <= k_d;
            low_q     <= low_d;
            cnt_q     <= cnt_d;
            i_q       <= i_d;
            j_q       <= j_d;
            carry_q   <= carry_d;
            out_idx_q <= out_idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (beat_in)              state_d = last_load ? S_COMPUTE : S_LOAD;
            S_LOAD:    if (beat_in && last_load) state_d = S_COMPUTE;
            S_COMPUTE: if (row_done && row_last) state_d = S_OUTPUT;
            S_OUTPUT:  if (beat_out && out_last) state_d = S_IDLE;
            default:                             state_d = S_IDLE;
        endcase
    end

    always_comb begin
        k_d       = k_q;
        low_d     = low_q;
        cnt_d     = cnt_q;
        i_d       = i_q;
        j_d       = j_q;
        carry_d   = carry_q;
        out_idx_d = out_idx_q;
        case (state_q)
            S_IDLE: begin
                if (beat_in) begin
                    k_d       = k_eff;
                    low_d     = bus.low_half_in;
                    cnt_d     = C_ONE;
                    i_d       = '0;
                    j_d       = '0;
                    carry_d   = '0;
                    out_idx_d = '0;
                end
            end
            S_LOAD: begin
                if (beat_in) cnt_d = cnt_q + C_ONE;
            end
            S_COMPUTE: begin
                if (row_done) begin
                    i_d     = '0;
                    j_d     = j_q + C_ONE;
                    carry_d = '0;
                end else begin
                    i_d     = i_q + C_ONE;
                    carry_d = mac[2*W-1:W];
                end
            end
            default: begin
                if (beat_out) out_idx_d = out_idx_q + C_ONE;
            end
        endcase
    end

    // Accumulator blocks [0, 2K) are scrubbed as operands load, so a reset
    // mid-operation never leaks partial sums into the next product.
    always_ff @(posedge clk_in) begin
        if (beat_in) begin
            n_mem[load_idx[AW-1:0]]   <= bus.n_in;
            m_mem[load_idx[AW-1:0]]   <= bus.m_in;
            acc_mem[load_idx]          <= '0;
            acc_mem[load_idx + load_k] <= '0;
        end
        if (state_q == S_COMPUTE) begin
            acc_mem[acc_idx] <= mac[W-1:0];
        end
        if (beat_out) begin
            acc_mem[out_idx_q] <= '0;
        end
    end

    always_comb begin
        ready_w       = armed_q && (state_q == S_IDLE || state_q == S_LOAD);
        valid_w       = (state_q == S_OUTPUT);
        bus.ready_out = ready_w;
        bus.valid_out = valid_w;
        bus.data_out  = valid_w ? acc_mem[out_idx_q] : '0;
        bus.final_out = valid_w && out_last;
    end
endmodule

`default_nettype wire

// File: tb/tb_bignum_multiplier_cfg.sv
`default_nettype none
// ============================================================================
// Module      : tb_bignum_multiplier_cfg
// Description : Self-checking bench for bignum_multiplier_cfg (8-bit blocks, K <= 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bignum_multiplier_cfg;
    localparam int RS = 8;
    localparam int MB = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    bignum_multiplier_cfg_if #(.REGISTER_SIZE(RS), .MAX_BITS(MB)) bus ();

    bignum_multiplier_cfg #(.REGISTER_SIZE(RS), .MAX_BITS(MB)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] got_data [8];
    bit         got_fin  [8];
    int         got_n, got_lat, got_bubbles, got_unstable, got_cycles;
    bit         got_timeout, send_timeout, ready_after_load;

    function automatic int eff_k(input int nb);
        return (nb == 0 || nb > 4) ? 4 : nb;
    endfunction

    // Exact product of the K-block operands, truncated to K blocks in low-half mode.
    function automatic logic [63:0] model_prod(input int k, input logic [31:0] n,
                                               input logic [31:0] m, input bit low);
        logic [63:0] mask;
        logic [63:0] p;
        mask = (64'd1 << (8 * k)) - 64'd1;
        p    = ({32'd0, n} & mask) * ({32'd0, m} & mask);
        return low ? (p & mask) : p;
    endfunction

    task automatic send_operands(input int nb, input logic [31:0] n, input logic [31:0] m,
                                 input bit low, input bit gaps);
        int k;
        int w;
        k = eff_k(nb);
        send_timeout = 0;
        for (int b = 0; b < k; b++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.valid_in = 1'b0;
                    @(negedge clk);
                end
            end
            bus.valid_in = 1'b1;
            bus.n_in     = n[8*b +: 8];
            bus.m_in     = m[8*b +: 8];
            // Length and mode only matter on the first beat; scramble them afterwards.
            bus.num_blocks_in = (b == 0) ? 3'(nb) : 3'($urandom_range(0, 7));
            bus.low_half_in   = (b == 0) ? low : 1'($urandom_range(0, 1));
            w = 0;
            while (!bus.ready_out && w < 50) begin
                @(negedge clk);
                w++;
            end
            if (!bus.ready_out) begin
                send_timeout = 1;
                break;
            end
            @(negedge clk);
        end
        bus.valid_in = 1'b0;
        bus.n_in     = 8'($urandom);
        bus.m_in     = 8'($urandom);
        ready_after_load = bus.ready_out;
    endtask

    task automatic collect(input int stall_mode);
        int   cyc;
        int   phase;
        bit   stalled;
        bit   rdy;
        logic [7:0] prev_d;
        bit   prev_f;
        got_n = 0; got_lat = 0; got_bubbles = 0; got_unstable = 0; got_cycles = 0;
        got_timeout = 0; cyc = 0; phase = 0; stalled = 0; prev_d = '0; prev_f = 0;
        while (!bus.valid_out && got_lat < 200) begin
            @(negedge clk);
            got_lat++;
        end
        if (!bus.valid_out) begin
            got_timeout = 1;
            return;
        end
        while (got_n < 8 && cyc < 200) begin
            if (!bus.valid_out) begin
                got_bubbles++;
            end else begin
                got_cycles++;
                if (stalled && (bus.data_out !== prev_d || bus.final_out !== prev_f))
                    got_unstable++;
                case (stall_mode)
                    0:       rdy = 1'b1;
                    1:       rdy = (phase % 3 == 0);
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                phase++;
                bus.ready_in = rdy;
                prev_d = bus.data_out;
                prev_f = bus.final_out;
                stalled = !rdy;
                if (rdy) begin
                    got_data[got_n] = bus.data_out;
                    got_fin[got_n]  = bus.final_out;
                    got_n++;
                    if (bus.final_out) begin
                        @(negedge clk);
                        bus.ready_in = 1'b0;
                        return;
                    end
                end
            end
            @(negedge clk);
            cyc++;
        end
        bus.ready_in = 1'b0;
        got_timeout = 1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({bus.ready_out, bus.valid_out, bus.final_out, bus.data_out} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b val=%b fin=%b data=%h, want all 0",
                     bus.ready_out, bus.valid_out, bus.final_out, bus.data_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.ready_out !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: got %b want 0", bus.ready_out);
        end
        @(negedge clk);
        checks++;
        if (bus.ready_out !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_edge: got %b want 1", bus.ready_out);
        end
    endtask

    task automatic test_k1_full();
        logic [63:0] exp;
        exp = 64'h0000_0000_0000_FE01;
        send_operands(1, 32'hFF, 32'hFF, 1'b0, 1'b0);
        collect(0);
        checks++;
        if (got_timeout || got_n !== 2) begin
            errors++;
            $display("FAIL k1_count: got %0d beats (timeout=%0b) want 2", got_n, got_timeout);
        end
        for (int b = 0; b < 2 && b < got_n; b++) begin
            checks++;
            if (got_data[b] !== exp[8*b +: 8] || got_fin[b] !== (b == 1)) begin
                errors++;
                $display("FAIL k1_beat%0d: got %h/fin%0b want %h/fin%0b",
                         b, got_data[b], got_fin[b], exp[8*b +: 8], (b == 1));
            end
        end
    endtask

    task automatic test_k4(input bit low);
        logic [63:0] exp;
        int L;
        int lim;
        exp = low ? 64'h0000_0000_0000_0001 : 64'hFFFF_FFFE_0000_0001;
        L   = low ? 4 : 8;
        lim = low ? 22 : 28;
        send_operands(4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, low, 1'b0);
        checks++;
        if (send_timeout || ready_after_load !== 1'b0) begin
            errors++;
            $display("FAIL k4_load low=%0b: timeout=%0b ready=%b want ready 0",
                     low, send_timeout, ready_after_load);
        end
        collect(0);
        checks++;
        if (got_timeout || got_n !== L || got_lat > lim) begin
            errors++;
            $display("FAIL k4_shape low=%0b: beats %0d lat %0d want %0d beats lat<=%0d",
                     low, got_n, got_lat, L, lim);
        end
        for (int b = 0; b < L && b < got_n; b++) begin
            checks++;
            if (got_data[b] !== exp[8*b +: 8] || got_fin[b] !== (b == L - 1)) begin
                errors++;
                $display("FAIL k4_beat%0d low=%0b: got %h/fin%0b want %h/fin%0b",
                         b, low, got_data[b], got_fin[b], exp[8*b +: 8], (b == L - 1));
            end
        end
        checks++;
        if (got_bubbles !== 0 || got_cycles !== L) begin
            errors++;
            $display("FAIL k4_stream low=%0b: bubbles %0d cycles %0d want 0 and %0d",
                     low, got_bubbles, got_cycles, L);
        end
        checks++;
        if (bus.ready_out !== 1'b1 || bus.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL k4_idle low=%0b: ready %b valid %b want 1 0",
                     low, bus.ready_out, bus.valid_out);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] exp;
        exp = 64'h0000_0000_0000_0306;
        send_operands(2, 32'h0102, 32'h0003, 1'b0, 1'b0);
        collect(1);
        checks++;
        if (got_timeout || got_n !== 4 || got_unstable !== 0) begin
            errors++;
            $display("FAIL bp_shape: beats %0d unstable %0d want 4 and 0", got_n, got_unstable);
        end
        for (int b = 0; b < 4 && b < got_n; b++) begin
            checks++;
            if (got_data[b] !== exp[8*b +: 8] || got_fin[b] !== (b == 3)) begin
                errors++;
                $display("FAIL bp_beat%0d: got %h/fin%0b want %h/fin%0b",
                         b, got_data[b], got_fin[b], exp[8*b +: 8], (b == 3));
            end
        end
    endtask

    task automatic test_back_to_back();
        send_operands(4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        collect(0);
        checks++;
        if (bus.ready_out !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: got %b want 1 right after final beat", bus.ready_out);
        end
        send_operands(1, 32'h02, 32'h03, 1'b0, 1'b0);
        collect(0);
        checks++;
        if (got_n !== 2 || got_data[0] !== 8'h06 || got_data[1] !== 8'h00 || !got_fin[1]) begin
            errors++;
            $display("FAIL b2b_result: got n=%0d %h %h fin%0b want 2 06 00 fin1",
                     got_n, got_data[0], got_data[1], got_fin[1]);
        end
    endtask

    task automatic test_clamp();
        logic [63:0] exp;
        exp = 64'hFFFF_FFFE_0000_0001;
        send_operands(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        checks++;
        if (send_timeout || ready_after_load !== 1'b0) begin
            errors++;
            $display("FAIL clamp_load: timeout=%0b ready=%b want ready 0 after 4 beats",
                     send_timeout, ready_after_load);
        end
        collect(0);
        checks++;
        if (got_n !== 8) begin
            errors++;
            $display("FAIL clamp_count: got %0d beats want 8", got_n);
        end
        for (int b = 0; b < 8 && b < got_n; b++) begin
            checks++;
            if (got_data[b] !== exp[8*b +: 8]) begin
                errors++;
                $display("FAIL clamp_beat%0d: got %h want %h", b, got_data[b], exp[8*b +: 8]);
            end
        end
    endtask

    task automatic test_reset_mid_compute();
        logic [63:0] exp;
        exp = 64'h0000_0000_0001_0000;
        send_operands(4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.ready_out, bus.valid_out, bus.final_out, bus.data_out} !== 11'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got rdy=%b val=%b fin=%b data=%h want all 0",
                     bus.ready_out, bus.valid_out, bus.final_out, bus.data_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.ready_out !== 1'b1 || bus.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle: ready %b valid %b want 1 0", bus.ready_out, bus.valid_out);
        end
        send_operands(2, 32'h0100, 32'h0100, 1'b0, 1'b0);
        collect(0);
        checks++;
        if (got_n !== 4) begin
            errors++;
            $display("FAIL midreset_count: got %0d want 4", got_n);
        end
        for (int b = 0; b < 4 && b < got_n; b++) begin
            checks++;
            if (got_data[b] !== exp[8*b +: 8]) begin
                errors++;
                $display("FAIL midreset_beat%0d: got %h want %h", b, got_data[b], exp[8*b +: 8]);
            end
        end
    endtask

    task automatic test_random();
        int lat_tab [5][2];
        int nb, k, L;
        bit low;
        logic [31:0] n, m;
        logic [63:0] exp;
        for (int a = 0; a < 5; a++) begin
            lat_tab[a][0] = -1;
            lat_tab[a][1] = -1;
        end
        for (int t = 0; t < 30; t++) begin
            nb  = $urandom_range(0, 7);
            k   = eff_k(nb);
            low = 1'($urandom_range(0, 1));
            n   = $urandom;
            m   = $urandom;
            L   = low ? k : 2 * k;
            exp = model_prod(k, n, m, low);
            send_operands(nb, n, m, low, 1'b1);
            collect(2);
            checks++;
            if (got_timeout || got_n !== L || got_unstable !== 0 ||
                got_lat > (low ? k * (k + 1) / 2 + k + 8 : k * (k + 1) + 8)) begin
                errors++;
                $display("FAIL rand%0d_shape k=%0d low=%0b: beats %0d lat %0d unstable %0d want %0d beats",
                         t, k, low, got_n, got_lat, got_unstable, L);
            end
            for (int b = 0; b < L && b < got_n; b++) begin
                checks++;
                if (got_data[b] !== exp[8*b +: 8] || got_fin[b] !== (b == L - 1)) begin
                    errors++;
                    $display("FAIL rand%0d_beat%0d k=%0d low=%0b: got %h/fin%0b want %h/fin%0b",
                             t, b, k, low, got_data[b], got_fin[b], exp[8*b +: 8], (b == L - 1));
                end
            end
            if (lat_tab[k][low] < 0) begin
                lat_tab[k][low] = got_lat;
            end else begin
                checks++;
                if (got_lat !== lat_tab[k][low]) begin
                    errors++;
                    $display("FAIL rand%0d_latency k=%0d low=%0b: got %0d want %0d",
                             t, k, low, got_lat, lat_tab[k][low]);
                end
            end
        end
    endtask

    initial begin
        bus.n_in          = '0;
        bus.m_in          = '0;
        bus.valid_in      = 1'b0;
        bus.num_blocks_in = '0;
        bus.low_half_in   = 1'b0;
        bus.ready_in      = 1'b0;
        test_reset();
        test_k1_full();
        test_k4(1'b0);
        test_k4(1'b1);
        test_backpressure();
        test_back_to_back();
        test_clamp();
        test_reset_mid_compute();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1);
    end
endmodule

`default_nettype wire
